multi_control_unit: RTL and testbench
=====================================

MULTI_CONTROL_UNIT -- requirements
Module: multi_control_unit

Interface
REQ-001 SHALL have port CLK_in, input, 1 bit: the single system clock; all state updates occur on its rising edge.
REQ-002 SHALL have port RST_in, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of CLK_in.
REQ-003 SHALL have port Stage, input, 5 bits: one-hot current stage from the stage sequencer; 10000 IF, 01000 ID, 00100 EXE, 00010 MEM, 00001 WB.
REQ-004 SHALL have port Instr_in, input, 32 bits: instruction-memory read data.
REQ-005 SHALL have port Zero_in, input, 1 bit: ALU zero flag, valid during EXE.
REQ-006 SHALL have port StageControl, output, 5 bits: stage request to the sequencer; bit2 EXE, bit1 MEM, bit0 WB; bits 4:3 always 0.
REQ-007 SHALL have port Halt_en, output, 1 bit: sticky halt flag that forces the sequencer to IF.
REQ-008 SHALL have port IR_out, output, 32 bits: registered instruction.
REQ-009 SHALL have ports IRWre, PCWre, RegWre, MemWre and MemRd, output, 1 bit each: write/read strobes.
REQ-010 SHALL have port ALUOp, output, 3 bits: 000 add, 001 sub, 010 or, 011 and, 100 slt.
REQ-011 SHALL have port PCSrc, output, 2 bits: 00 PC+4, 01 branch target, 10 jump target.
REQ-012 SHALL have port InstrCount, output, 16 bits: count of retired instructions.

Function
REQ-013 SHALL load IR with Instr_in on a clock edge where Stage=IF and Halt_en=0; IR SHALL hold at all other edges.
REQ-014 SHALL decode from IR combinationally as follows.
- R-type: opcode 000000, nonzero word, funct add/sub/or/and/slt = 100000/100010/100101/100100/101010.
- addi 001000 / ori 001101 / andi 001100 / slti 001010.
- lw 100011; sw 101011; beq 000100; bne 000101; j 000010; halt 111111.
REQ-015 SHALL drive StageControl as follows: R-type and I-ALU 00101; lw 00111; sw 00110; beq/bne 00100; j, halt, all-zero word and any unknown opcode or funct 00000.
REQ-016 SHALL set IRWre = Stage[4] & ~Halt_en.
REQ-017 SHALL assert PCWre only in the final stage of the instruction, i.e. the stage from which the sequencer returns to IF given StageControl, and never while Halt_en=1 or for a halt instruction.
- j, nop and unknown: PCWre in ID.
- beq/bne: PCWre in EXE.
- sw: PCWre in MEM.
- ALU ops and lw: PCWre in WB.
REQ-018 SHALL set PCSrc as follows, and SHALL drive 00 when PCWre=0.
- 10 for j.
- 01 for beq when Zero_in=1, or for bne when Zero_in=0.
- 00 otherwise.
REQ-019 SHALL set RegWre = Stage[0] & (R-type | I-ALU | lw), MemWre = Stage[1] & sw, and MemRd = Stage[1] & lw.
REQ-020 SHALL set ALUOp from funct for R-type.
- addi, lw and sw: 000.
- beq and bne: 001.
- ori: 010.
- andi: 011.
- slti: 100.
- Otherwise: 000.
REQ-021 SHALL set Halt_en to 1 on the clock edge where Stage=ID and the IR opcode is halt; Halt_en SHALL then remain 1 until reset.
REQ-022 SHALL increment InstrCount by 1 on each clock edge where PCWre=1, wrapping from FFFF to 0000; a halt instruction SHALL NOT be counted.
REQ-023 SHALL give RST_in priority over all other state updates at the same edge.
REQ-024 SHALL treat an illegal (non-one-hot) Stage value as no stage: all strobes 0, no state change except reset.

Reset
REQ-025 SHALL, one edge after RST_in=1, have IR=0, Halt_en=0 and InstrCount=0.
- Resulting outputs: StageControl=00000, ALUOp=000, PCSrc=00.
- With Stage=IF: IRWre=1 and all other strobes 0.
REQ-026 SHALL apply reset mid-instruction (any Stage) at that edge, discarding the in-flight instruction without counting it.

Verification
REQ-027 SHALL cover this scenario: lw (0x8C220004) fetched, Stage walked IF->ID->EXE->MEM->WB -> StageControl=00111 in ID, MemRd=1 only in MEM, RegWre=1 and PCWre=1 only in WB, InstrCount 0->1.
REQ-028 SHALL cover this scenario: beq with Zero_in=1 in EXE -> StageControl=00100, PCWre=1, PCSrc=01 in EXE; the same with Zero_in=0 -> PCSrc=00.
REQ-029 SHALL cover this scenario: j (0x08000010) -> StageControl=00000, PCWre=1 and PCSrc=10 in ID, no RegWre/MemWre.
REQ-030 SHALL cover this scenario: halt (0xFC000000) through IF, ID -> Halt_en=1 after the ID edge, IRWre=0, PCWre=0, IR unchanged, InstrCount unchanged over 10 further cycles with Instr_in toggling.
REQ-031 SHALL cover this scenario: InstrCount preloaded to FFFF via 65535 nops, one more nop retired -> InstrCount=0000.
REQ-032 SHALL cover this scenario: RST_in asserted during MEM of sw after halt state set -> Halt_en=0, IR=0, InstrCount=0, MemWre=0 at the following edge.

Source files
------------

// File: rtl/multi_control_unit.sv
// Multi-cycle control unit: registers the fetched instruction, decodes it into
// per-stage strobes/ALU controls, and tracks halt state and retired-instruction count.
module multi_control_unit (
    input  logic        CLK_in,
    input  logic        RST_in,
    input  logic [4:0]  Stage,
    input  logic [31:0] Instr_in,
    input  logic        Zero_in,
    output logic [4:0]  StageControl,
    output logic        Halt_en,
    output logic [31:0] IR_out,
    output logic        IRWre,
    output logic        PCWre,
    output logic        RegWre,
    output logic        MemWre,
    output logic        MemRd,
    output logic [2:0]  ALUOp,
    output logic [1:0]  PCSrc,
    output logic [15:0] InstrCount
);

    typedef enum logic [3:0] {
        CLS_NONE,
        CLS_RALU,
        CLS_IALU,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_BNE,
        CLS_J,
        CLS_HALT
    } instr_cls_e;

    logic [31:0] ir_q, ir_d;
    logic        halt_q, halt_d;
    logic [15:0] cnt_q, cnt_d;

    logic [5:0]  opcode, funct;
    instr_cls_e  cls;
    logic [2:0]  alu_op;
    logic        is_if, is_id, is_exe, is_mem, is_wb;
    logic        final_stage;
    logic [4:0]  stage_ctl;
    logic        ir_wre, pc_wre, reg_wre, mem_wre, mem_rd;
    logic [1:0]  pc_src;

    // Exact one-hot compares: any illegal Stage value selects no stage at all.
    always_comb begin
        is_if  = (Stage == 5'b10000);
        is_id  = (Stage == 5'b01000);
        is_exe = (Stage == 5'b00100);
        is_mem = (Stage == 5'b00010);
        is_wb  = (Stage == 5'b00001);
    end

    always_comb begin
        opcode = ir_q[31:26];
        funct  = ir_q[5:0];
        cls    = CLS_NONE;
        alu_op = 3'b000;
        case (opcode)
            6'b000000: begin
                if (ir_q != '0) begin
                    case (funct)
                        6'b100000: begin cls = CLS_RALU; alu_op = 3'b000; end
                        6'b100010: begin cls = CLS_RALU; alu_op = 3'b001; end
                        6'b100101: begin cls = CLS_RALU; alu_op = 3'b010; end
                        6'b100100: begin cls = CLS_RALU; alu_op = 3'b011; end
                        6'b101010: begin cls = CLS_RALU; alu_op = 3'b100; end
                        default:   cls = CLS_NONE;
                    endcase
                end
            end
            6'b001000: begin cls = CLS_IALU; alu_op = 3'b000; end
            6'b001101: begin cls = CLS_IALU; alu_op = 3'b010; end
            6'b001100: begin cls = CLS_IALU; alu_op = 3'b011; end
            6'b001010: begin cls = CLS_IALU; alu_op = 3'b100; end
            6'b100011: cls = CLS_LW;
            6'b101011: cls = CLS_SW;
            6'b000100: begin cls = CLS_BEQ; alu_op = 3'b001; end
            6'b000101: begin cls = CLS_BNE; alu_op = 3'b001; end
            6'b000010: cls = CLS_J;
            6'b111111: cls = CLS_HALT;
            default:   cls = CLS_NONE;
        endcase
    end

    // The final stage is the one from which the sequencer returns to IF.
    always_comb begin
        stage_ctl   = 5'b00000;
        final_stage = 1'b0;
        case (cls)
            CLS_RALU, CLS_IALU: begin stage_ctl = 5'b00101; final_stage = is_wb;  end
            CLS_LW:             begin stage_ctl = 5'b00111; final_stage = is_wb;  end
            CLS_SW:             begin stage_ctl = 5'b00110; final_stage = is_mem; end
            CLS_BEQ, CLS_BNE:   begin stage_ctl = 5'b00100; final_stage = is_exe; end
            CLS_HALT:           final_stage = 1'b0;
            default:            final_stage = is_id;
        endcase

        ir_wre  = is_if & ~halt_q;
        pc_wre  = final_stage & ~halt_q;
        reg_wre = is_wb & ((cls == CLS_RALU) | (cls == CLS_IALU) | (cls == CLS_LW));
        mem_wre = is_mem & (cls == CLS_SW);
        mem_rd  = is_mem & (cls == CLS_LW);

        pc_src = 2'b00;
        if (pc_wre) begin
            if (cls == CLS_J)
                pc_src = 2'b10;
            else if (((cls == CLS_BEQ) & Zero_in) | ((cls == CLS_BNE) & ~Zero_in))
                pc_src = 2'b01;
        end
    end

    always_comb begin
        ir_d   = ir_wre ? Instr_in : ir_q;
        halt_d = halt_q | (is_id & (cls == CLS_HALT));
        cnt_d  = cnt_q + {15'd0, pc_wre};
    end

    always_ff @(posedge CLK_in) begin
        if (RST_in) begin
            ir_q   <= '0;
            halt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            ir_q   <= ir_d;
            halt_q <= halt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign StageControl = stage_ctl;
    assign Halt_en      = halt_q;
    assign IR_out       = ir_q;
    assign IRWre        = ir_wre;
    assign PCWre        = pc_wre;
    assign RegWre       = reg_wre;
    assign MemWre       = mem_wre;
    assign MemRd        = mem_rd;
    assign ALUOp        = alu_op;
    assign PCSrc        = pc_src;
    assign InstrCount   = cnt_q;

endmodule

// File: tb/tb_multi_control_unit.sv
// Directed self-checking bench for multi_control_unit.
module tb_multi_control_unit;

    localparam logic [4:0] S_IF  = 5'b10000;
    localparam logic [4:0] S_ID  = 5'b01000;
    localparam logic [4:0] S_EXE = 5'b00100;
    localparam logic [4:0] S_MEM = 5'b00010;
    localparam logic [4:0] S_WB  = 5'b00001;

    localparam logic [31:0] I_LW   = 32'h8C220004;
    localparam logic [31:0] I_SW   = 32'hAC220004;
    localparam logic [31:0] I_BEQ  = 32'h10220003;
    localparam logic [31:0] I_BNE  = 32'h14220003;
    localparam logic [31:0] I_SUB  = 32'h00221822;
    localparam logic [31:0] I_SLT  = 32'h0022182A;
    localparam logic [31:0] I_ORI  = 32'h34220005;
    localparam logic [31:0] I_BADF = 32'h00221823;
    localparam logic [31:0] I_J    = 32'h08000010;
    localparam logic [31:0] I_HALT = 32'hFC000000;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  stage;
    logic [31:0] instr;
    logic        zero;
    logic [4:0]  stage_control;
    logic        halt_en;
    logic [31:0] ir;
    logic        ir_wre, pc_wre, reg_wre, mem_wre, mem_rd;
    logic [2:0]  alu_op;
    logic [1:0]  pc_src;
    logic [15:0] instr_count;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    multi_control_unit dut (
        .CLK_in       (clk),
        .RST_in       (rst),
        .Stage        (stage),
        .Instr_in     (instr),
        .Zero_in      (zero),
        .StageControl (stage_control),
        .Halt_en      (halt_en),
        .IR_out       (ir),
        .IRWre        (ir_wre),
        .PCWre        (pc_wre),
        .RegWre       (reg_wre),
        .MemWre       (mem_wre),
        .MemRd        (mem_rd),
        .ALUOp        (alu_op),
        .PCSrc        (pc_src),
        .InstrCount   (instr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Strobe vector {IRWre, PCWre, RegWre, MemWre, MemRd}.
    function automatic logic [31:0] strobes();
        return {27'd0, ir_wre, pc_wre, reg_wre, mem_wre, mem_rd};
    endfunction

    task automatic fetch(input logic [31:0] w);
        stage = S_IF;
        instr = w;
        tick();
    endtask

    initial begin
        rst   = 1'b1;
        stage = S_IF;
        instr = 32'hDEADBEEF;
        zero  = 1'b0;
        tick();

        // Reset state
        chk("rst_ir", ir, 32'h0);
        chk("rst_halt", {31'd0, halt_en}, 32'd0);
        chk("rst_cnt", {16'd0, instr_count}, 32'd0);
        chk("rst_sc", {27'd0, stage_control}, 32'd0);
        chk("rst_aluop", {29'd0, alu_op}, 32'd0);
        chk("rst_pcsrc", {30'd0, pc_src}, 32'd0);
        chk("rst_strobes", strobes(), 32'b10000);
        rst = 1'b0;

        // lw walked through all five stages
        fetch(I_LW);
        chk("lw_ir", ir, I_LW);
        stage = S_ID;  #1;
        chk("lw_id_sc", {27'd0, stage_control}, 32'b00111);
        chk("lw_id_strobes", strobes(), 32'b00000);
        chk("lw_id_aluop", {29'd0, alu_op}, 32'd0);
        tick();
        stage = S_EXE; #1;
        chk("lw_exe_strobes", strobes(), 32'b00000);
        tick();
        stage = S_MEM; #1;
        chk("lw_mem_strobes", strobes(), 32'b00001);
        tick();
        stage = S_WB;  #1;
        chk("lw_wb_strobes", strobes(), 32'b01100);
        chk("lw_wb_cnt", {16'd0, instr_count}, 32'd0);
        tick();
        chk("lw_cnt", {16'd0, instr_count}, 32'd1);

        // beq taken, beq not taken, bne taken
        fetch(I_BEQ);
        stage = S_ID; #1;
        chk("beq_id_sc", {27'd0, stage_control}, 32'b00100);
        chk("beq_id_aluop", {29'd0, alu_op}, 32'b001);
        chk("beq_id_strobes", strobes(), 32'b00000);
        tick();
        stage = S_EXE; zero = 1'b1; #1;
        chk("beq_t_strobes", strobes(), 32'b01000);
        chk("beq_t_pcsrc", {30'd0, pc_src}, 32'b01);
        tick();
        chk("beq_t_cnt", {16'd0, instr_count}, 32'd2);
        fetch(I_BEQ);
        stage = S_EXE; zero = 1'b0; #1;
        chk("beq_n_pcwre", {31'd0, pc_wre}, 32'd1);
        chk("beq_n_pcsrc", {30'd0, pc_src}, 32'b00);
        tick();
        fetch(I_BNE);
        stage = S_EXE; zero = 1'b0; #1;
        chk("bne_t_pcsrc", {30'd0, pc_src}, 32'b01);
        zero = 1'b1; #1;
        chk("bne_n_pcsrc", {30'd0, pc_src}, 32'b00);
        tick();
        chk("bne_cnt", {16'd0, instr_count}, 32'd4);

        // R-type / I-ALU decode
        fetch(I_SUB);
        stage = S_ID; #1;
        chk("sub_sc", {27'd0, stage_control}, 32'b00101);
        chk("sub_aluop", {29'd0, alu_op}, 32'b001);
        stage = S_WB; #1;
        chk("sub_wb_strobes", strobes(), 32'b01100);
        tick();
        chk("sub_cnt", {16'd0, instr_count}, 32'd5);
        fetch(I_SLT);
        stage = S_ID; #1;
        chk("slt_aluop", {29'd0, alu_op}, 32'b100);
        fetch(I_ORI);
        stage = S_ID; #1;
        chk("ori_sc", {27'd0, stage_control}, 32'b00101);
        chk("ori_aluop", {29'd0, alu_op}, 32'b010);

        // sw retires in MEM
        fetch(I_SW);
        stage = S_ID; #1;
        chk("sw_sc", {27'd0, stage_control}, 32'b00110);
        stage = S_MEM; #1;
        chk("sw_mem_strobes", strobes(), 32'b01010);
        tick();
        chk("sw_cnt", {16'd0, instr_count}, 32'd6);

        // Unknown funct behaves like a nop
        fetch(I_BADF);
        stage = S_ID; #1;
        chk("badf_sc", {27'd0, stage_control}, 32'd0);
        chk("badf_strobes", strobes(), 32'b01000);
        chk("badf_aluop", {29'd0, alu_op}, 32'd0);

        // j retires in ID
        fetch(I_J);
        stage = S_ID; #1;
        chk("j_sc", {27'd0, stage_control}, 32'd0);
        chk("j_strobes", strobes(), 32'b01000);
        chk("j_pcsrc", {30'd0, pc_src}, 32'b10);
        tick();
        chk("j_cnt", {16'd0, instr_count}, 32'd7);

        // Illegal stage values are ignored
        stage = 5'b11000; instr = I_LW; #1;
        chk("ill_if_strobes", strobes(), 32'd0);
        tick();
        chk("ill_ir", ir, I_J);
        stage = 5'b01100; #1;
        chk("ill_id_strobes", strobes(), 32'd0);
        tick();
        chk("ill_cnt", {16'd0, instr_count}, 32'd7);

        // halt sets the sticky flag and freezes IR and count
        fetch(I_HALT);
        stage = S_ID; #1;
        chk("halt_id_strobes", strobes(), 32'd0);
        chk("halt_id_sc", {27'd0, stage_control}, 32'd0);
        tick();
        chk("halt_set", {31'd0, halt_en}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            stage = i[0] ? S_ID : S_IF;
            instr = i[0] ? I_SW : I_LW;
            #1;
            chk("halted_strobes", strobes(), 32'd0);
            tick();
            chk("halted_ir", ir, I_HALT);
            chk("halted_cnt", {16'd0, instr_count}, 32'd7);
        end

        // Reset during MEM with halt set
        stage = S_MEM; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_halt", {31'd0, halt_en}, 32'd0);
        chk("rst2_ir", ir, 32'd0);
        chk("rst2_cnt", {16'd0, instr_count}, 32'd0);
        chk("rst2_memwre", {31'd0, mem_wre}, 32'd0);

        // Reset in MEM of an in-flight sw discards it uncounted
        fetch(I_SW);
        stage = S_MEM; #1;
        chk("sw2_memwre", {31'd0, mem_wre}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst3_cnt", {16'd0, instr_count}, 32'd0);
        chk("rst3_ir", ir, 32'd0);
        chk("rst3_memwre", {31'd0, mem_wre}, 32'd0);

        // Counter wrap: IR is the all-zero nop, retiring once per ID edge
        stage = S_ID; #1;
        chk("nop_strobes", strobes(), 32'b01000);
        repeat (65535) tick();
        chk("cnt_ffff", {16'd0, instr_count}, 32'h0000FFFF);
        tick();
        chk("cnt_wrap", {16'd0, instr_count}, 32'h00000000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
